rf_multiport_sb: RTL

- Parametrised integer register file for the pipelined core: NRD asynchronous read ports, one synchronous write port with built-in writeback-source select, and write-through bypass.
- Adds a per-register pending-write scoreboard: decode marks a destination busy at issue, writeback clears it, and per-port busy/stall flags feed the hazard unit.
- Sits between decode (read/issue side) and writeback (write side).

---
 rtl/rf_multiport_sb.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rf_multiport_sb.sv
// Integer register file: NRD async read ports, one sync write port, per-register pending-write scoreboard.
// Latency: reads, bypass, rd_busy and stall are combinational; writes and scoreboard updates land on the rising clk edge.
// Backpressure: none inside the block; stall is raised toward the hazard unit when a consumed operand is still pending.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   rR / rD                    packed read addresses / read data, port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   rd_busy, rd_use, stall     per-port pending flag, per-port operand-used, combined hazard stall
//   we, wR, rf_wsel            writeback enable, destination, source select
//   alu_c, sext, dram_rdo, pc4 writeback source candidates; wb_value is the selected one
//   issue_valid, issue_rd      marks a destination pending at issue
//   busy_vec                   scoreboard state, bit i = register i pending
// Optional: define RF_BYPASS_EN for write-through bypass on rD and the bypass term in rd_busy.

`ifndef WB_ALU
`define WB_ALU  3'd0
`endif
`ifndef WB_EXT
`define WB_EXT  3'd1
`endif
`ifndef WB_DRAM
`define WB_DRAM 3'd2
`endif
`ifndef WB_PC4
`define WB_PC4  3'd3
`endif

module rf_multiport_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rR,
    output logic [NRD*XLEN-1:0] rD,
    output logic [NRD-1:0]      rd_busy,
    output logic                stall,
    input  logic [NRD-1:0]      rd_use,
    input  logic                we,
    input  logic [AW-1:0]       wR,
    input  logic [2:0]          rf_wsel,
    input  logic [XLEN-1:0]     alu_c,
    input  logic [XLEN-1:0]     sext,
    input  logic [XLEN-1:0]     dram_rdo,
    input  logic [XLEN-1:0]     pc4,
    output logic [XLEN-1:0]     wb_value,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREG-1:0]     busy_vec
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_nxt;

    // Writeback source select; unknown codes fall back to the ALU result.
    always_comb begin
        case (rf_wsel)
            `WB_ALU:  wb_value = alu_c;
            `WB_EXT:  wb_value = sext;
            `WB_DRAM: wb_value = dram_rdo;
            `WB_PC4:  wb_value = pc4;
            default:  wb_value = alu_c;
        endcase
    end

    // Register storage; r0 is never written when it is hardwired to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we && !(ZR && (wR == '0))) begin
            regs[wR] <= wb_value;
        end
    end

    // Scoreboard: clear first, then set, so a same-cycle set on the same
    // register wins (the newly issued write is still in flight).
    always_comb begin
        busy_nxt = busy;
        if (we) begin
            busy_nxt[wR] = 1'b0;
        end
        if (issue_valid && !(ZR && (issue_rd == '0))) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;

        assign addr    = rR[k*AW +: AW];
        assign is_zero = ZR && (addr == '0);

`ifdef RF_BYPASS_EN
        // A write landing this edge resolves the hazard now: forward it and
        // drop the busy flag. Held off during reset so rD reads 0 then.
        logic hit;
        assign hit = rst_n && we && (wR == addr);
        assign rD[k*XLEN +: XLEN] = is_zero ? '0 : (hit ? wb_value : regs[addr]);
        assign rd_busy[k]         = !is_zero && busy[addr] && !hit;
`else
        assign rD[k*XLEN +: XLEN] = is_zero ? '0 : regs[addr];
        assign rd_busy[k]         = !is_zero && busy[addr];
`endif
    end

    assign stall = |(rd_busy & rd_use);

endmodule
